// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register file's single write port.
// Optional same-cycle read bypass of the staged write under `REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          A3,
  output logic [DATA_W-1:0]          WD3,
  output logic                       pend_valid,
  output logic [ADDR_W-1:0]          pend_addr,
  output logic [$clog2(NREQ)-1:0]    grant_id
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]          rd_a1,
  input  logic [ADDR_W-1:0]          rd_a2,
  input  logic [DATA_W-1:0]          rf_rd1,
  input  logic [DATA_W-1:0]          rf_rd2,
  output logic [DATA_W-1:0]          fwd_rd1,
  output logic [DATA_W-1:0]          fwd_rd2
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];

  logic [IW-1:0]     ptr_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [IW-1:0]     gid_r;

  logic [NREQ-1:0]   ready_s;
  logic              gnt_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [IW:0]       sum_s;
  logic [IW-1:0]     idx_s;
  logic [IW-1:0]     ptr_nxt_s;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin scan starting at ptr; first valid requester wins unless stalled.
  always_comb begin
    ready_s   = {NREQ{1'b0}};
    gnt_s     = 1'b0;
    gnt_idx_s = {IW{1'b0}};
    sum_s     = {(IW+1){1'b0}};
    idx_s     = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(NREQ)) begin
        sum_s = sum_s - (IW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IW-1:0];
      if (!stall && !gnt_s && req_valid[idx_s]) begin
        gnt_s          = 1'b1;
        gnt_idx_s      = idx_s;
        ready_s[idx_s] = 1'b1;
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  // Pointer advances past the granted index, wrapping at NREQ-1.
  always_comb begin
    if (gnt_idx_s == IW'(NREQ-1)) begin
      ptr_nxt_s = {IW{1'b0}};
    end else begin
      ptr_nxt_s = gnt_idx_s + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  // Output stage: a grant captures the winner; x0 destinations never assert the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r  <= {IW{1'b0}};
      we_r   <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
      gid_r  <= {IW{1'b0}};
    end else if (gnt_s) begin
      ptr_r  <= ptr_nxt_s;
      we_r   <= (addr_a[gnt_idx_s] != {ADDR_W{1'b0}});
      addr_r <= addr_a[gnt_idx_s];
      data_r <= data_a[gnt_idx_s];
      gid_r  <= gnt_idx_s;
    end else begin
      we_r   <= 1'b0;
    end
  end

  assign req_ready  = ready_s;
  assign RegWrite   = we_r;
  assign A3         = addr_r;
  assign WD3        = data_r;
  assign pend_valid = we_r;
  assign pend_addr  = addr_r;
  assign grant_id   = gid_r;

`ifdef REGFILE_WB_BYPASS_EN
  // Readers of the staged destination see the value being written this cycle.
  always_comb begin
    if (we_r && (rd_a1 == addr_r) && (rd_a1 != {ADDR_W{1'b0}})) begin
      fwd_rd1 = data_r;
    end else begin
      fwd_rd1 = rf_rd1;
    end
    if (we_r && (rd_a2 == addr_r) && (rd_a2 != {ADDR_W{1'b0}})) begin
      fwd_rd2 = data_r;
    end else begin
      fwd_rd2 = rf_rd2;
    end
  end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite/A3/WD3) between NREQ writeback requesters, e.g. ALU writeback and multicycle load/mul units.
- Uses a valid/ready handshake per requester with round-robin arbitration.
- Registers the granted write in one output stage that drives the register file directly.
- Suppresses writes to x0 and exports a pending-write indication for hazard logic.

Parameters:
- NREQ, 2, number of writeback requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  high = grant nothing this cycle.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*ADDR_W  destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  one-hot or zero; a handshake completes when valid and ready are both high.
- RegWrite  output  1  register file write enable (registered).
- A3  output  ADDR_W  register file write address (registered).
- WD3  output  DATA_W  register file write data (registered).
- pend_valid  output  1  stage holds a write that lands at the next edge; equals RegWrite.
- pend_addr  output  ADDR_W  equals A3; for hazard detection.
- grant_id  output  $clog2(NREQ)  index of the last granted requester (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - RegWrite=0, A3=0, WD3=0, grant_id=0.
  - RR pointer = 0 (requester 0 has highest priority).
  - Reset takes effect immediately, mid-transaction included; an in-flight staged write is dropped and never reaches the register file.
- Arbitration, combinational each cycle:
  - If stall=1 or no req_valid is set: req_ready = 0.
  - Otherwise, scan indices ptr, ptr+1, ... mod NREQ; the first with req_valid=1 gets req_ready=1. All others get 0.
  - req_ready may depend on req_valid.
  - A requester must hold valid, addr and data stable until accepted.
- Stage update on rising edge:
  - On a grant to index g: A3<=req_addr[g], WD3<=req_data[g], grant_id<=g, ptr<=(g+1) mod NREQ.
  - RegWrite <= 1 if req_addr[g]!=0, else 0. x0 writes are accepted (handshake completes) but never drive RegWrite.
  - No grant: RegWrite<=0; A3, WD3, grant_id and ptr hold.
- Latency:
  - Handshake at edge N. RegWrite/A3/WD3 are valid during cycle N+1. The register file captures the write at edge N+1.
  - Throughput: one write per cycle, no bubbles.
- Simultaneous events:
  - Several valids in one cycle: exactly one is granted, by RR order. Losers keep valid asserted and are served in later cycles.
  - Same destination from two requesters: writes land in grant order; the later grant wins.
  - stall=1 blocks new grants only. A write already staged still completes at the next edge.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles.
- Wrap-around: ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds the following ports.
  - Inputs: rd_a1, rd_a2 (ADDR_W), rf_rd1, rf_rd2 (DATA_W).
  - Outputs: fwd_rd1, fwd_rd2 (DATA_W).
  - fwd_rdk = WD3 when RegWrite=1 and rd_ak==A3 and rd_ak!=0; otherwise rf_rdk. This is purely combinational.
  - Readers therefore see the staged value in the same cycle it is being written.
- Undefined: these ports do not exist and no bypass logic is built.

Test Plan:
- Reset, then a single request (req0: addr=5, data=0xDEADBEEF) -> req_ready[0]=1 that cycle; next cycle RegWrite=1, A3=5, WD3=0xDEADBEEF, grant_id=0; the following cycle RegWrite=0.
- req0 and req1 both valid for 4 cycles (addr 1/2) -> grants 0,1,0,1; A3 sequence 1,2,1,2; RegWrite high for 4 consecutive cycles.
- Request with addr=0, data=0x1234 -> handshake completes, RegWrite stays 0, ptr advances.
- stall=1 while req1 valid (addr=7) -> req_ready=0 and RegWrite=0 the next cycle; drop stall -> grant on that cycle, A3=7 one cycle later.
- rst pulsed low while a write is staged (A3=9) -> RegWrite=0 immediately (asynchronous), A3=0; after release, requester 0 has priority.
- With REGFILE_WB_BYPASS_EN: staged write A3=3, WD3=0xAA and rd_a1=3 -> fwd_rd1=0xAA; rd_a2=4 -> fwd_rd2=rf_rd2; rd_a1=0 with A3=0 -> never forwarded.
